// File: rtl/uart_transmitter.sv
// UART transmitter: 11-bit frame (start, 8 data MSB first, parity, stop) serializer
// fed through a one-byte valid/ready holding buffer.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST     = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE_LAST = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [7:0]    hold_buf;
  logic          full;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_idx;
  logic [BW-1:0] baud_cnt;

  logic baud_end;
  logic accept;
  logic parity_bit;

  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign accept     = tx_valid && !full;
  assign parity_bit = (^shift_reg) ^ PARITY_ODD;
  assign tx_ready   = !full;
  assign busy       = (state != IDLE);

  // frame_done is registered one cycle early so it lines up with the final stop cycle.
  // Accept and load never coincide: accept needs !full, load needs full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_buf   <= '0;
      full       <= 1'b0;
      shift_reg  <= '0;
      bit_idx    <= '0;
      baud_cnt   <= '0;
      tx_out     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == STOP) && (baud_cnt == BAUD_PRE_LAST);

      if (accept) begin
        hold_buf <= tx_data;
        full     <= 1'b1;
      end

      if (state != IDLE) begin
        baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);
      end

      unique case (state)
        IDLE: begin
          if (full) begin
            shift_reg <= hold_buf;
            full      <= 1'b0;
            baud_cnt  <= '0;
            tx_out    <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_end) begin
            bit_idx <= 3'd7;
            tx_out  <= shift_reg[7];
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_idx == 3'd0) begin
              tx_out <= parity_bit;
              state  <= PARITY;
            end else begin
              bit_idx <= bit_idx - 3'd1;
              tx_out  <= shift_reg[bit_idx - 3'd1];
            end
          end
        end
        PARITY: begin
          if (baud_end) begin
            tx_out <= 1'b1;
            state  <= STOP;
          end
        end
        STOP: begin
          if (baud_end) begin
            if (full) begin
              shift_reg <= hold_buf;
              full      <= 1'b0;
              tx_out    <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: an even- and an odd-parity instance share stimulus and are
// checked every cycle against a frame-position model, plus literal frame expectations.
module tb_uart_transmitter;

  localparam int CPB   = 4;
  localparam int FRAME = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  logic ready_e, out_e, busy_e, fd_e;
  logic ready_o, out_o, busy_o, fd_o;

  int total = 0;
  int bad   = 0;

  // Model: a pending-byte slot and a frame position counter (0..FRAME-1) while active.
  bit         m_full   = 1'b0;
  bit         m_active = 1'b0;
  bit         m_acc    = 1'b0;
  logic [7:0] m_buf    = 8'h00;
  logic [7:0] m_byte   = 8'h00;
  int         m_pos    = 0;
  int         m_acc_cnt = 0;
  int         fd_seen  = 0;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_e), .tx_out(out_e), .busy(busy_e), .frame_done(fd_e)
  );

  uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_o), .tx_out(out_o), .busy(busy_o), .frame_done(fd_o)
  );

  always #5 clk = ~clk;

  // Line level at a given cycle of a frame, straight from the frame layout.
  function automatic logic exp_bit(input logic [7:0] b, input int pos, input bit odd);
    int k;
    k = pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[8 - k];
    if (k == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flagTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout expected completion", name);
  endtask

  // Model update on each edge; a load only happens from a slot that was already full.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_full   = 1'b0;
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      m_acc = tx_valid && !m_full;
      if (m_active) begin
        if (m_pos == FRAME - 1) begin
          if (m_full) begin
            m_byte = m_buf;
            m_full = 1'b0;
            m_pos  = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_pos++;
        end
      end else if (m_full) begin
        m_byte   = m_buf;
        m_full   = 1'b0;
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (m_acc) begin
        m_full = 1'b1;
        m_buf  = tx_data;
        m_acc_cnt++;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    checkOutput("even tx_out", out_e, m_active ? exp_bit(m_byte, m_pos, 1'b0) : 1'b1);
    checkOutput("odd tx_out", out_o, m_active ? exp_bit(m_byte, m_pos, 1'b1) : 1'b1);
    checkOutput("even tx_ready", ready_e, !m_full);
    checkOutput("odd tx_ready", ready_o, !m_full);
    checkOutput("even busy", busy_e, m_active);
    checkOutput("odd busy", busy_o, m_active);
    checkOutput("even frame_done", fd_e, m_active && (m_pos == FRAME - 1));
    checkOutput("odd frame_done", fd_o, m_active && (m_pos == FRAME - 1));
    if (fd_e) fd_seen++;
  end

  // Offer one byte and return at the falling edge after it has been taken.
  task automatic applyStimulus(input logic [7:0] b, input bit keep);
    int start_cnt;
    int n;
    start_cnt = m_acc_cnt;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (m_acc_cnt == start_cnt && n < 1000);
    if (!keep) tx_valid = 1'b0;
    if (n >= 1000) flagTimeout("accept wait");
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((m_active || m_full) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) flagTimeout("idle wait");
    repeat (3) @(negedge clk);
  endtask

  // Sample mid-bit of each of the 11 bits of the frame that loads on the next edge.
  task automatic captureFrame(output logic [10:0] be, output logic [10:0] bo,
                              output int fd_cnt, output int fd_at);
    be = '0;
    bo = '0;
    fd_cnt = 0;
    fd_at = -1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i % CPB == 1) begin
        be[10 - i / CPB] = out_e;
        bo[10 - i / CPB] = out_o;
      end
      if (fd_e) begin
        fd_cnt++;
        fd_at = i;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [10:0] be;
    logic [10:0] bo;
    int fd_cnt;
    int fd_at;
    int run;
    int n;
    int ready_low;
    int acc0;

    $display("[TB] uart_transmitter bench start");

    // Reset values, then a long idle stretch
    repeat (3) @(negedge clk);
    checkOutput("reset tx_out", out_e, 1);
    checkOutput("reset tx_ready", ready_e, 1);
    checkOutput("reset busy", busy_e, 0);
    checkOutput("reset frame_done", fd_e, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("idle tx_out", out_e, 1);

    // 0xA5: even line 0 10100101 0 1, odd parity bit flips
    applyStimulus(8'hA5, 1'b0);
    captureFrame(be, bo, fd_cnt, fd_at);
    checkOutput("a5 even frame", be, 11'b01010010101);
    checkOutput("a5 odd frame", bo, 11'b01010010111);
    checkOutput("a5 frame_done count", fd_cnt, 1);
    checkOutput("a5 frame_done cycle", fd_at, FRAME - 1);
    @(negedge clk);
    checkOutput("a5 busy after stop", busy_e, 0);

    // Parity corners
    applyStimulus(8'h00, 1'b0);
    captureFrame(be, bo, fd_cnt, fd_at);
    checkOutput("00 odd frame", bo, 11'b00000000011);
    checkOutput("00 even frame", be, 11'b00000000001);
    waitIdle();
    applyStimulus(8'hFF, 1'b0);
    captureFrame(be, bo, fd_cnt, fd_at);
    checkOutput("ff odd frame", bo, 11'b01111111111);
    checkOutput("ff even frame", be, 11'b01111111101);
    waitIdle();

    // Back-to-back: 0xC3 offered during the DATA bits of 0x3C
    applyStimulus(8'h3C, 1'b0);
    run = 0;
    n = 0;
    ready_low = 0;
    acc0 = m_acc_cnt;
    @(negedge clk);
    while (busy_e && n < 400) begin
      run++;
      n++;
      if (run == 12) begin
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        acc0 = m_acc_cnt;
      end
      @(negedge clk);
      if (tx_valid && m_acc_cnt != acc0) tx_valid = 1'b0;
      if (!ready_e) ready_low++;
    end
    tx_valid = 1'b0;
    checkOutput("b2b busy run", run, 2 * FRAME);
    checkOutput("b2b ready low cycles", ready_low, 32);
    waitIdle();

    // Producer stall with valid held across three bytes
    fd_seen = 0;
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'h66, 1'b1);
    applyStimulus(8'h77, 1'b0);
    waitIdle();
    checkOutput("stall frame_done count", fd_seen, 3);

    // Reset during DATA index 3 of 0x81 with 0x99 buffered
    applyStimulus(8'h81, 1'b0);
    applyStimulus(8'h99, 1'b0);
    n = 0;
    while (!(m_active && m_pos == 21) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) flagTimeout("mid-frame wait");
    checkOutput("pre-reset line", out_e, 0);
    checkOutput("pre-reset tx_ready", ready_e, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset tx_out", out_e, 1);
    checkOutput("async reset frame_done", fd_e, 0);
    checkOutput("async reset tx_ready", ready_e, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("post-reset busy", busy_e, 0);

    // Clean frame after reset: 0x42 -> 0 01000010 p 1
    applyStimulus(8'h42, 1'b0);
    captureFrame(be, bo, fd_cnt, fd_at);
    checkOutput("42 even frame", be, 11'b00100001001);
    checkOutput("42 odd frame", bo, 11'b00100001011);
    checkOutput("42 frame_done count", fd_cnt, 1);
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
